// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low patterns, special codes, and reader FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational active-low segment pattern to digit code lookup.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] code
);

  always_comb begin
    code = CODE_INVALID;
    case (pat)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Recovers digit codes from a multiplexed active-low 7-segment bus; a digit is
// committed after its slot settles and the same value repeats CONFIRM scans in a row.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CONFIRM       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    err
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int CONF_W = $clog2(CONFIRM + 1);

  logic [6:0]            seg_p0, seg_p1;
  logic [NUM_DIGITS-1:0] an_p0, an_p1;

  state_t                state, state_nx;
  logic                  latch;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      lat_idx;
  logic [6:0]            lat_pat;

  logic                  sel_one;
  logic [IDX_W-1:0]      sel_idx;
  int                    zeros;
  logic [NUM_DIGITS-1:0] slot_mask;
  logic                  slot_match;
  logic                  pat_match;

  logic [3:0]                       code;
  logic [NUM_DIGITS-1:0][3:0]       dig_r;
  logic [NUM_DIGITS-1:0][3:0]       cand;
  logic [NUM_DIGITS-1:0][CONF_W-1:0] conf;
  logic [CONF_W-1:0]                conf_nx;

  // Stage p0/p1: two-flop synchronizer; idle bus state (all off) on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_p0 <= SEG_BLANK;
      seg_p1 <= SEG_BLANK;
      an_p0  <= '1;
      an_p1  <= '1;
    end else begin
      seg_p0 <= seg_n;
      seg_p1 <= seg_p0;
      an_p0  <= an_n;
      an_p1  <= an_p0;
    end
  end

  always_comb begin
    zeros   = 0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_p1[i]) begin
        zeros   = zeros + 1;
        sel_idx = IDX_W'(i);
      end
    end
    sel_one = (zeros == 1);
  end

  assign slot_mask  = ~(NUM_DIGITS'(1) << lat_idx);
  assign slot_match = (an_p1 == slot_mask);
  assign pat_match  = (seg_p1 == lat_pat);

  // Slot tracking FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_one) begin
          latch    = 1'b1;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (!(slot_match && pat_match))            state_nx = IDLE;
        else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nx = SAMPLE;
      end
      SAMPLE:  state_nx = HOLD;
      HOLD:    if (!slot_match) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (latch)           cnt <= '0;
    else if (state == SETTLE) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      lat_idx <= sel_idx;
      lat_pat <= seg_p1;
    end
  end

  seg_pattern_decode u_dec (
    .pat  (lat_pat),
    .code (code)
  );

  // Confidence count saturates at CONFIRM; a new candidate restarts at one
  always_comb begin
    if (code == cand[lat_idx])
      conf_nx = (conf[lat_idx] == CONF_W'(CONFIRM)) ? conf[lat_idx] : conf[lat_idx] + 1'b1;
    else
      conf_nx = CONF_W'(1);
  end

  // Commit stage: all outputs update on the edge that ends SAMPLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_r       <= {NUM_DIGITS{CODE_BLANK}};
      cand        <= {NUM_DIGITS{CODE_BLANK}};
      conf        <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      err         <= 1'b0;
    end else begin
      update <= 1'b0;
      err    <= 1'b0;
      if (state == SAMPLE) begin
        if (code == CODE_INVALID) begin
          err                  <= 1'b1;
          conf[lat_idx]        <= '0;
          digit_valid[lat_idx] <= 1'b0;
        end else begin
          cand[lat_idx] <= code;
          conf[lat_idx] <= conf_nx;
          if (conf_nx == CONF_W'(CONFIRM)) begin
            digit_valid[lat_idx] <= 1'b1;
            if (code != dig_r[lat_idx]) begin
              dig_r[lat_idx] <= code;
              update         <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign digits = dig_r;

endmodule
